rx_bit_timer: RTL and testbench
===============================

RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, width of the bit-period count.
REQ-002 SHALL have parameter BIT_CNT_BITS, default 4, width of the frame bit count.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  start-bit detected pulse, arms a frame.
REQ-006 SHALL have port abort  input  1  cancel frame, return to idle.
REQ-007 SHALL have port bit_period  input  NUM_CNT_BITS  clocks per bit.
REQ-008 SHALL have port frame_bits  input  BIT_CNT_BITS  bits per frame, start and stop bits included.
REQ-009 SHALL have port shift_strobe  output  1  one-cycle sample/shift pulse at bit centre.
REQ-010 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, HALF, BIT, DONE; all outputs registered.
REQ-013 SHALL, in IDLE with start=1 at edge E, latch bit_period and frame_bits, set cycle count to 1, clear bit count, and enter HALF.
REQ-014 SHALL clamp the latched period to 2 when bit_period<2, and the latched bit count to 1 when frame_bits=0.
REQ-015 SHALL use half = latched period >> 1 (floor, minimum 1).
REQ-016 SHALL, in HALF, when cycle count equals half, pulse shift_strobe, set bit count to 1, reload the cycle count to 1, and enter BIT (or DONE if latched bits=1); otherwise increment the cycle count.
REQ-017 SHALL place the first shift_strobe high in the cycle after edge E+half.
REQ-018 SHALL, in BIT, when cycle count equals latched period, pulse shift_strobe, increment bit count, and reload the cycle count to 1; on reaching latched bits, enter DONE.
REQ-019 SHALL space consecutive shift_strobe pulses exactly latched-period cycles apart.
REQ-020 SHALL, in DONE, pulse frame_done for one cycle and return to IDLE; frame_done is high in the cycle after the last strobe.
REQ-021 SHALL drive busy=1 in HALF, BIT and DONE; busy=0 in IDLE, including the frame_done cycle.
REQ-022 SHALL ignore start when not in IDLE; bit_period and frame_bits changes mid-frame SHALL have no effect.
REQ-023 SHALL, on abort=1 in any state, enter IDLE next edge, clear the counters, and suppress shift_strobe and frame_done; abort SHALL win over a simultaneous start or terminal count.
REQ-024 SHALL accept start in the cycle immediately following frame_done (back-to-back frames).

Reset
REQ-025 SHALL, with n_rst=0 at a rising edge, force IDLE, counters 0, shift_strobe=0, frame_done=0, busy=0; reset SHALL override start and abort.
REQ-026 SHALL treat reset asserted mid-frame identically, with no pulse emitted afterwards.

Configuration
REQ-027 SHALL, with macro RX_BIT_TIMER_STATS_EN defined, add output frame_count (8 bits): reset to 0, incremented on each frame_done, saturating at 255, unaffected by abort.
REQ-028 SHALL, without RX_BIT_TIMER_STATS_EN, have no frame_count port or logic.

Structure
REQ-029 SHALL take the state enum typedef and constant MIN_BIT_PERIOD=2 from shared package rx_timer_pkg.
REQ-030 SHALL place the cycle counter (sync clear/load-1, increment, equality compare) in sub-module rx_cycle_counter; all other logic lives in the top level.

Verification
REQ-031 SHALL cover: n_rst=0 for 2 edges during an active frame -> next cycle all outputs 0, busy=0, no later pulses.
REQ-032 SHALL cover: bit_period=8, frame_bits=10, start at edge 0 -> strobes after edges 4,12,...,76 (10 total), frame_done after edge 77, busy=0 from edge 77.
REQ-033 SHALL cover: bit_period=1, frame_bits=3 -> period clamped to 2, strobes after edges 1,3,5, frame_done after edge 6.
REQ-034 SHALL cover: abort one cycle after the 3rd strobe (bit_period=8) -> no further strobes, no frame_done, busy=0 next cycle; a new start then times normally.
REQ-035 SHALL cover: start re-pulsed and bit_period changed to 4 mid-frame -> strobe spacing stays at 8.
REQ-036 SHALL cover: with RX_BIT_TIMER_STATS_EN, 300 back-to-back frames (frame_bits=1) -> frame_count=255.

Source files
------------

// File: rtl/rx_timer_pkg.sv
// Shared definitions for the receive bit timer slice.
//
// Contents:
//   rx_state_t      - timer FSM states (IDLE, HALF, BIT, DONE)
//   MIN_BIT_PERIOD  - smallest bit period the timer will run with
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    BIT  = 2'd2,
    DONE = 2'd3
  } rx_state_t;

  localparam int MIN_BIT_PERIOD = 2;

endpackage : rx_timer_pkg

// File: rtl/rx_cycle_counter.sv
// Cycle counter used by the receive bit timer to measure time inside a bit.
//
// Ports:
//   clk      - clock, rising edge
//   n_rst    - synchronous active-low reset (count -> 0)
//   clear    - synchronous clear to 0
//   load_one - synchronous load of 1 (start of a new timed interval)
//   inc      - advance the count by one
//   target   - value the count is compared against
//   match    - high while count equals target
//
// Priority of the controls is reset > clear > load_one > inc.
module rx_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             load_one,
  input  logic             inc,
  input  logic [WIDTH-1:0] target,
  output logic             match
);

  logic [WIDTH-1:0] count;

  // The interval always restarts at 1 rather than 0, so that a target of N
  // matches on exactly the Nth cycle after the reload edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= WIDTH'(1);
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign match = (count == target);

endmodule : rx_cycle_counter

// File: rtl/rx_bit_timer.sv
// Receive bit timer: after a start-bit detection pulse, produces a
// sample/shift strobe at the centre of every bit of a frame, followed by a
// one-cycle end-of-frame pulse.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   n_rst        - synchronous active-low reset, overrides everything
//   start        - start-bit detected pulse, arms a frame when idle
//   abort        - cancel the frame in progress, back to idle
//   bit_period   - clocks per bit (values below 2 run as 2)
//   frame_bits   - bits per frame including start/stop (0 runs as 1)
//   shift_strobe - one-cycle pulse at each bit centre
//   frame_done   - one-cycle pulse in the cycle after the last strobe
//   busy         - high while a frame is in progress
//   frame_count  - (only with RX_BIT_TIMER_STATS_EN) saturating count of
//                  completed frames
//
// Optional feature macro: RX_BIT_TIMER_STATS_EN adds the frame_count output.
import rx_timer_pkg::*;

module rx_bit_timer #(
  parameter int NUM_CNT_BITS = 4,
  parameter int BIT_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CNT_BITS-1:0] bit_period,
  input  logic [BIT_CNT_BITS-1:0] frame_bits,
  output logic                    shift_strobe,
  output logic                    frame_done,
  output logic                    busy
`ifdef RX_BIT_TIMER_STATS_EN
  ,
  output logic [7:0]              frame_count
`endif
);

  rx_state_t state;
  rx_state_t next_state;

  logic [NUM_CNT_BITS-1:0] period_q;
  logic [NUM_CNT_BITS-1:0] period_in;
  logic [NUM_CNT_BITS-1:0] half_period;
  logic [NUM_CNT_BITS-1:0] cnt_target;
  logic [BIT_CNT_BITS-1:0] bits_q;
  logic [BIT_CNT_BITS-1:0] bits_in;
  logic [BIT_CNT_BITS-1:0] bit_cnt;
  logic [BIT_CNT_BITS-1:0] bit_cnt_d;

  logic latch_en;
  logic cnt_clear;
  logic cnt_load;
  logic cnt_inc;
  logic cnt_match;
  logic strobe_d;
  logic done_d;
  logic busy_d;

  // Clamp the frame configuration before it is latched, so the running
  // frame never sees an illegal period or an empty frame.
  assign period_in = (bit_period < NUM_CNT_BITS'(MIN_BIT_PERIOD)) ?
                     NUM_CNT_BITS'(MIN_BIT_PERIOD) : bit_period;
  assign bits_in   = (frame_bits == '0) ? BIT_CNT_BITS'(1) : frame_bits;

  // Half a bit to reach the centre of the start bit; never less than one.
  assign half_period = ((period_q >> 1) == '0) ? NUM_CNT_BITS'(1) :
                       (period_q >> 1);

  // The counter compares against the half period only while hunting for the
  // centre of the start bit, and against the full period afterwards.
  assign cnt_target = (state == HALF) ? half_period : period_q;

  rx_cycle_counter #(
    .WIDTH (NUM_CNT_BITS)
  ) u_cycle_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (cnt_clear),
    .load_one (cnt_load),
    .inc      (cnt_inc),
    .target   (cnt_target),
    .match    (cnt_match)
  );

  // State register, frame configuration latch, bit counter and the
  // registered outputs. Everything visible outside is a flop so the
  // strobes are glitch-free and line up exactly with the counted edges.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      period_q     <= '0;
      bits_q       <= '0;
      bit_cnt      <= '0;
      shift_strobe <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= next_state;
      bit_cnt      <= bit_cnt_d;
      shift_strobe <= strobe_d;
      frame_done   <= done_d;
      busy         <= busy_d;
      if (latch_en) begin
        period_q <= period_in;
        bits_q   <= bits_in;
      end
    end
  end

  // Next-state and next-output logic. Abort is decoded ahead of the state
  // case so it beats both a simultaneous start and a terminal count, and it
  // suppresses any pulse that would otherwise have been produced.
  always_comb begin
    next_state = state;
    bit_cnt_d  = bit_cnt;
    latch_en   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    strobe_d   = 1'b0;
    done_d     = 1'b0;

    if (abort) begin
      next_state = IDLE;
      bit_cnt_d  = '0;
      cnt_clear  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            latch_en   = 1'b1;
            cnt_load   = 1'b1;
            bit_cnt_d  = '0;
            next_state = HALF;
          end
        end
        HALF: begin
          if (cnt_match) begin
            strobe_d   = 1'b1;
            bit_cnt_d  = BIT_CNT_BITS'(1);
            cnt_load   = 1'b1;
            next_state = (bits_q == BIT_CNT_BITS'(1)) ? DONE : BIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        BIT: begin
          if (cnt_match) begin
            strobe_d  = 1'b1;
            bit_cnt_d = bit_cnt + BIT_CNT_BITS'(1);
            cnt_load  = 1'b1;
            if ((bit_cnt + BIT_CNT_BITS'(1)) == bits_q) begin
              next_state = DONE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DONE: begin
          done_d     = 1'b1;
          cnt_clear  = 1'b1;
          bit_cnt_d  = '0;
          next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end

    // busy follows the state being entered, so it already reads 0 in the
    // cycle frame_done is high.
    busy_d = (next_state != IDLE);
  end

`ifdef RX_BIT_TIMER_STATS_EN
  // Completed-frame counter. It advances together with frame_done, so an
  // aborted frame (which never pulses frame_done) is never counted.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      frame_count <= 8'd0;
    end else if (done_d && (frame_count != 8'hFF)) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule : rx_bit_timer

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer.
//
// The reference model describes a frame only by its start edge, clamped
// period and bit count; expected outputs after each edge are derived from
// those numbers with plain arithmetic.
module tb_rx_bit_timer;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       abort;
  logic [3:0] bit_period;
  logic [3:0] frame_bits;
  logic       shift_strobe;
  logic       frame_done;
  logic       busy;
`ifdef RX_BIT_TIMER_STATS_EN
  logic [7:0] frame_count;
`endif

  rx_bit_timer #(
    .NUM_CNT_BITS (4),
    .BIT_CNT_BITS (4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .abort        (abort),
    .bit_period   (bit_period),
    .frame_bits   (frame_bits),
    .shift_strobe (shift_strobe),
    .frame_done   (frame_done),
    .busy         (busy)
`ifdef RX_BIT_TIMER_STATS_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int evals = 0;
  int fails = 0;

  // Reference model state: edge index and description of the current frame.
  int t = 0;
  bit m_active = 0;
  int m_start = 0;
  int m_per = 0;
  int m_bits = 0;
  int m_half = 0;
  int m_done_t = 0;
  int m_frames = 0;

  logic [3:0] hold_per = 4'd8;
  logic [3:0] hold_fb  = 4'd10;

  int strobe_times[$];
  int done_times[$];

  task automatic checkBit(input string tag, input logic got, input logic exp);
    evals++;
    assert (got === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s edge=%0d got=%b expected=%b", tag, t, got, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int got, input int exp);
    evals++;
    assert (got === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Compare all outputs after edge t against the frame description.
  task automatic checkOutput();
    int  d;
    logic e_strobe;
    logic e_done;
    logic e_busy;
    d        = t - m_start;
    e_strobe = m_active && (d >= m_half) && (((d - m_half) % m_per) == 0) &&
               (((d - m_half) / m_per) < m_bits);
    e_done   = m_active && (t == m_done_t);
    e_busy   = m_active && (t >= m_start) && (t < m_done_t);
    checkBit("shift_strobe", shift_strobe, e_strobe);
    checkBit("frame_done", frame_done, e_done);
    checkBit("busy", busy, e_busy);
`ifdef RX_BIT_TIMER_STATS_EN
    checkInt("frame_count", int'(frame_count), m_frames);
`endif
    if (shift_strobe === 1'b1) strobe_times.push_back(t);
    if (frame_done === 1'b1) done_times.push_back(t);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic applyStimulus(input logic st, input logic ab,
                               input logic [3:0] per, input logic [3:0] fb,
                               input logic rn);
    bit idle_now;
    start      = st;
    abort      = ab;
    bit_period = per;
    frame_bits = fb;
    n_rst      = rn;
    @(posedge clk);
    t++;
    idle_now = !m_active || (t > m_done_t);
    if (!rn) begin
      m_active = 0;
      m_frames = 0;
    end else if (ab) begin
      m_active = 0;
    end else if (st && idle_now) begin
      m_active = 1;
      m_start  = t;
      m_per    = (per < 4'd2) ? 2 : int'(per);
      m_bits   = (fb == 4'd0) ? 1 : int'(fb);
      m_half   = m_per / 2;
      m_done_t = m_start + m_half + (m_bits - 1) * m_per + 1;
    end
    if (rn && !ab && m_active && (t == m_done_t) && (m_frames < 255))
      m_frames++;
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, hold_per, hold_fb, 1'b1);
  endtask

  int s0;

  initial begin
    start = 0; abort = 0; bit_period = 4'd8; frame_bits = 4'd10; n_rst = 0;

    // Reset: outputs quiet even with start and abort asserted.
    applyStimulus(1'b1, 1'b1, 4'd8, 4'd10, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd8, 4'd10, 1'b0);
    idleCycles(3);

    // Nominal 8-clock, 10-bit frame.
    $display("[TB] nominal frame");
    hold_per = 4'd8; hold_fb = 4'd10;
    strobe_times.delete(); done_times.delete();
    applyStimulus(1'b1, 1'b0, 4'd8, 4'd10, 1'b1);
    s0 = t;
    idleCycles(85);
    checkInt("nominal_strobe_count", strobe_times.size(), 10);
    checkInt("nominal_done_count", done_times.size(), 1);
    if (strobe_times.size() == 10) begin
      checkInt("nominal_first_strobe", strobe_times[0] - s0, 4);
      checkInt("nominal_last_strobe", strobe_times[9] - s0, 76);
    end
    if (done_times.size() == 1) checkInt("nominal_done_edge", done_times[0] - s0, 77);

    // Clamped period: bit_period=1 runs as 2.
    $display("[TB] clamped period");
    hold_per = 4'd1; hold_fb = 4'd3;
    strobe_times.delete(); done_times.delete();
    applyStimulus(1'b1, 1'b0, 4'd1, 4'd3, 1'b1);
    s0 = t;
    idleCycles(10);
    checkInt("clamp_strobe_count", strobe_times.size(), 3);
    if (done_times.size() == 1) checkInt("clamp_done_edge", done_times[0] - s0, 6);
    else checkInt("clamp_done_count", done_times.size(), 1);

    // Zero frame_bits runs as a single-bit frame.
    hold_per = 4'd4; hold_fb = 4'd0;
    applyStimulus(1'b1, 1'b0, 4'd4, 4'd0, 1'b1);
    idleCycles(8);

    // Abort one cycle after the third strobe, then a fresh frame.
    $display("[TB] abort mid-frame");
    hold_per = 4'd8; hold_fb = 4'd10;
    strobe_times.delete(); done_times.delete();
    applyStimulus(1'b1, 1'b0, 4'd8, 4'd10, 1'b1);
    idleCycles(20);
    applyStimulus(1'b1, 1'b1, 4'd8, 4'd10, 1'b1);
    idleCycles(90);
    checkInt("abort_strobe_count", strobe_times.size(), 3);
    checkInt("abort_done_count", done_times.size(), 0);
    strobe_times.delete();
    applyStimulus(1'b1, 1'b0, 4'd8, 4'd10, 1'b1);
    idleCycles(85);
    checkInt("after_abort_strobe_count", strobe_times.size(), 10);

    // Start re-pulsed with a shorter period mid-frame: spacing stays 8.
    $display("[TB] mid-frame changes ignored");
    strobe_times.delete();
    applyStimulus(1'b1, 1'b0, 4'd8, 4'd6, 1'b1);
    hold_per = 4'd8; hold_fb = 4'd6;
    idleCycles(9);
    applyStimulus(1'b1, 1'b0, 4'd4, 4'd2, 1'b1);
    hold_per = 4'd4; hold_fb = 4'd2;
    idleCycles(50);
    checkInt("respin_strobe_count", strobe_times.size(), 6);
    for (int i = 1; i < strobe_times.size(); i++)
      checkInt("respin_spacing", strobe_times[i] - strobe_times[i-1], 8);

    // Reset held for two edges during a frame.
    $display("[TB] reset mid-frame");
    hold_per = 4'd8; hold_fb = 4'd10;
    strobe_times.delete(); done_times.delete();
    applyStimulus(1'b1, 1'b0, 4'd8, 4'd10, 1'b1);
    idleCycles(15);
    applyStimulus(1'b0, 1'b0, 4'd8, 4'd10, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd8, 4'd10, 1'b0);
    strobe_times.delete(); done_times.delete();
    idleCycles(100);
    checkInt("post_reset_strobes", strobe_times.size(), 0);
    checkInt("post_reset_done", done_times.size(), 0);

    // 300 back-to-back single-bit frames with start held high.
    $display("[TB] back-to-back frames");
    done_times.delete();
    for (int i = 0; i < 900; i++) applyStimulus(1'b1, 1'b0, 4'd2, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd2, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd2, 4'd1, 1'b1);
    checkInt("b2b_done_count", done_times.size(), 300);
`ifdef RX_BIT_TIMER_STATS_EN
    checkInt("b2b_frame_count_sat", int'(frame_count), 255);
`endif

    // Randomized traffic with occasional aborts and resets.
    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 99) == 0),
                    4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 299) != 0));
    end
    idleCycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule : tb_rx_bit_timer
